// File: rtl/xm_stage.sv
// Execute-to-memory pipeline register: captures the ALU result and control fields,
// resolves bne/blt into a one-cycle redirect, squashes the wrong-path beat and maps overflow to rstatus.
module xm_stage #(
    parameter int DW      = 32,
    parameter int RSTATUS = 30
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_opcode,
    input  logic [4:0]    in_aluop,
    input  logic [4:0]    in_rd,
    input  logic [DW-1:0] in_target,
    input  logic [DW-1:0] in_storeData,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_overflow,
    input  logic          alu_isNotEqual,
    input  logic          alu_isLessThan,
    input  logic          mem_stall,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic [4:0]    out_rd,
    output logic [DW-1:0] out_storeData,
    output logic [4:0]    out_opcode,
    output logic          out_we,
    output logic          branch_taken,
    output logic [DW-1:0] branch_target
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    // Exception code written to rstatus; 0 means this opcode/aluop never raises overflow.
    function automatic logic [1:0] ovfCode(input logic [4:0] opcode, input logic [4:0] aluop);
        logic [1:0] code;
        code = 2'd0;
        if (opcode == OP_RTYPE && aluop == ALU_ADD) code = 2'd1;
        else if (opcode == OP_ADDI)                 code = 2'd2;
        else if (opcode == OP_RTYPE && aluop == ALU_SUB) code = 2'd3;
        return code;
    endfunction

    function automatic logic writesReg(input logic [4:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_LW);
    endfunction

    logic          vld_p1;
    logic [DW-1:0] result_p1;
    logic [4:0]    rd_p1;
    logic [DW-1:0] storeData_p1;
    logic [4:0]    opcode_p1;
    logic          we_p1;
    logic          taken_p1;
    logic [DW-1:0] target_p1;
    logic          squashPending;

    logic          accept;
    logic          taken;
    logic [1:0]    excCode;
    logic          raiseExc;

    always_comb begin
        accept   = in_valid && !mem_stall;
        taken    = ((in_opcode == OP_BNE) && alu_isNotEqual) ||
                   ((in_opcode == OP_BLT) && alu_isLessThan);
        excCode  = ovfCode(in_opcode, in_aluop);
        raiseExc = alu_overflow && (excCode != 2'd0);
    end

    // ---- execute -> memory stage boundary ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1        <= 1'b0;
            result_p1     <= '0;
            rd_p1         <= '0;
            storeData_p1  <= '0;
            opcode_p1     <= '0;
            we_p1         <= 1'b0;
            taken_p1      <= 1'b0;
            target_p1     <= '0;
            squashPending <= 1'b0;
        end else if (mem_stall) begin
            taken_p1 <= 1'b0;
        end else if (!accept) begin
            vld_p1   <= 1'b0;
            we_p1    <= 1'b0;
            rd_p1    <= '0;
            taken_p1 <= 1'b0;
        end else if (squashPending) begin
            // Wrong-path beat behind a taken branch: its own branch/overflow is dropped too.
            vld_p1        <= 1'b0;
            we_p1         <= 1'b0;
            rd_p1         <= '0;
            taken_p1      <= 1'b0;
            squashPending <= 1'b0;
        end else begin
            vld_p1       <= 1'b1;
            opcode_p1    <= in_opcode;
            storeData_p1 <= in_storeData;
            we_p1        <= writesReg(in_opcode);
            if (raiseExc) begin
                result_p1 <= {{(DW-2){1'b0}}, excCode};
                rd_p1     <= 5'(RSTATUS);
            end else begin
                result_p1 <= alu_result;
                rd_p1     <= writesReg(in_opcode) ? in_rd : 5'd0;
            end
            taken_p1      <= taken;
            squashPending <= taken;
            if (taken) target_p1 <= in_target;
        end
    end

    assign in_ready      = !mem_stall;
    assign out_valid     = vld_p1;
    assign out_result    = result_p1;
    assign out_rd        = rd_p1;
    assign out_storeData = storeData_p1;
    assign out_opcode    = opcode_p1;
    assign out_we        = we_p1;
    assign branch_taken  = taken_p1;
    assign branch_target = target_p1;

endmodule
